// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU/external requesters, the arbiter and the
// memory controller. The master modport is the arbiter's view; slave is
// the view of everything around it (requesters and memory).
interface cpu_mem_arbiter_if;
   logic        i_read_req;
   logic        i_read_w;
   logic        i_read_hw;
   logic [31:0] i_read_adr;
   logic        d_read_req;
   logic        d_read_w;
   logic        d_read_hw;
   logic [31:0] d_read_adr;
   logic        d_write_req;
   logic        d_write_w;
   logic        d_write_hw;
   logic [31:0] d_write_adr;
   logic [31:0] d_write_data;
   logic        read_valid;
   logic [31:0] read_data;
   logic        write_finish;
   logic        ext_req;
   logic        ext_we;
   logic [31:0] ext_adr;
   logic [31:0] ext_wdata;
   logic        ext_done;
   logic [31:0] ext_rdata;
   logic        mem_req;
   logic        mem_we;
   logic        mem_w;
   logic        mem_hw;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_wdone;
   logic        bus_err;
   logic [31:0] bus_err_adr;
   logic [1:0]  owner;

   modport master (
      input  i_read_req, i_read_w, i_read_hw, i_read_adr,
      input  d_read_req, d_read_w, d_read_hw, d_read_adr,
      input  d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
      input  ext_req, ext_we, ext_adr, ext_wdata,
      input  mem_rvalid, mem_rdata, mem_wdone,
      output read_valid, read_data, write_finish,
      output ext_done, ext_rdata,
      output mem_req, mem_we, mem_w, mem_hw, mem_adr, mem_wdata,
      output bus_err, bus_err_adr, owner
   );

   modport slave (
      output i_read_req, i_read_w, i_read_hw, i_read_adr,
      output d_read_req, d_read_w, d_read_hw, d_read_adr,
      output d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
      output ext_req, ext_we, ext_adr, ext_wdata,
      output mem_rvalid, mem_rdata, mem_wdone,
      input  read_valid, read_data, write_finish,
      input  ext_done, ext_rdata,
      input  mem_req, mem_we, mem_w, mem_hw, mem_adr, mem_wdata,
      input  bus_err, bus_err_adr, owner
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter: CPU ifetch / data read / data write plus one
// external master, one transaction at a time with a response timeout.
module cpu_mem_arbiter #(
   parameter int unsigned TMO_CYC = 255,
   parameter int unsigned TMO_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   cpu_mem_arbiter_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_CD   = 2'd2;
   localparam logic [1:0] OWN_EXT  = 2'd3;

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

   logic [1:0]       r_state;
   logic [1:0]       r_owner;
   logic             r_rr;        // 0: CPU wins a tie, 1: EXT wins a tie
   logic [TMO_W-1:0] r_cnt;
   logic             r_mem_req;
   logic             r_mem_we;
   logic             r_mem_w;
   logic             r_mem_hw;
   logic [31:0]      r_mem_adr;
   logic [31:0]      r_mem_wdata;
   logic             r_read_valid;
   logic [31:0]      r_read_data;
   logic             r_write_finish;
   logic             r_ext_done;
   logic [31:0]      r_ext_rdata;
   logic             r_bus_err;
   logic [31:0]      r_bus_err_adr;

   logic             w_cpu_any;
   logic             w_any;
   logic             w_pick_ext;
   logic [1:0]       w_g_owner;
   logic             w_g_we;
   logic             w_g_w;
   logic             w_g_hw;
   logic [31:0]      w_g_adr;
   logic [31:0]      w_g_wdata;
   logic             w_resp;
   logic             w_tmo;
   logic [TMO_W-1:0] w_cnt_inc;

   // Pick the winning requester and the command it would issue
   always_comb begin
      w_cpu_any  = bus.d_write_req | bus.d_read_req | bus.i_read_req;
      w_any      = w_cpu_any | bus.ext_req;
      w_pick_ext = bus.ext_req & (~w_cpu_any | r_rr);
      w_g_owner  = OWN_IF;
      w_g_we     = 1'b0;
      w_g_w      = bus.i_read_w;
      w_g_hw     = bus.i_read_hw;
      w_g_adr    = bus.i_read_adr;
      w_g_wdata  = '0;
      if (w_pick_ext) begin
         w_g_owner = OWN_EXT;
         w_g_we    = bus.ext_we;
         w_g_w     = 1'b1;
         w_g_hw    = 1'b0;
         w_g_adr   = bus.ext_adr;
         w_g_wdata = bus.ext_wdata;
      end else if (bus.d_write_req) begin
         w_g_owner = OWN_CD;
         w_g_we    = 1'b1;
         w_g_w     = bus.d_write_w;
         w_g_hw    = bus.d_write_hw;
         w_g_adr   = bus.d_write_adr;
         w_g_wdata = bus.d_write_data;
      end else if (bus.d_read_req) begin
         w_g_owner = OWN_CD;
         w_g_w     = bus.d_read_w;
         w_g_hw    = bus.d_read_hw;
         w_g_adr   = bus.d_read_adr;
      end
      // both size bits set means word
      if (w_g_w) w_g_hw = 1'b0;
   end

   // Response of the matching type, and timeout when no response arrives
   always_comb begin
      w_resp    = r_mem_we ? bus.mem_wdone : bus.mem_rvalid;
      w_cnt_inc = r_cnt + 1'b1;
      w_tmo     = ~w_resp & (w_cnt_inc == TMO_LIM);
   end

   // Transaction FSM with all outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_owner        <= OWN_NONE;
         r_rr           <= 1'b0;
         r_cnt          <= '0;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_w        <= 1'b0;
         r_mem_hw       <= 1'b0;
         r_mem_adr      <= '0;
         r_mem_wdata    <= '0;
         r_read_valid   <= 1'b0;
         r_read_data    <= '0;
         r_write_finish <= 1'b0;
         r_ext_done     <= 1'b0;
         r_ext_rdata    <= '0;
         r_bus_err      <= 1'b0;
         r_bus_err_adr  <= '0;
      end else begin
         r_mem_req      <= 1'b0;
         r_read_valid   <= 1'b0;
         r_write_finish <= 1'b0;
         r_ext_done     <= 1'b0;
         r_bus_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state     <= S_WAIT;
                  r_owner     <= w_g_owner;
                  r_rr        <= ~w_pick_ext;
                  r_cnt       <= '0;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_g_we;
                  r_mem_w     <= w_g_w;
                  r_mem_hw    <= w_g_hw;
                  r_mem_adr   <= w_g_adr;
                  r_mem_wdata <= w_g_wdata;
               end
            end
            S_WAIT: begin
               if (w_resp | w_tmo) begin
                  r_state <= S_DONE;
                  if (r_owner == OWN_EXT) begin
                     r_ext_done <= 1'b1;
                     if (!r_mem_we) r_ext_rdata <= w_resp ? bus.mem_rdata : '0;
                  end else if (r_mem_we) begin
                     r_write_finish <= 1'b1;
                  end else begin
                     r_read_valid <= 1'b1;
                     r_read_data  <= w_resp ? bus.mem_rdata : '0;
                  end
                  if (w_tmo) begin
                     r_bus_err     <= 1'b1;
                     r_bus_err_adr <= r_mem_adr;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_owner <= OWN_NONE;
            end
         endcase
      end
   end

   assign bus.mem_req      = r_mem_req;
   assign bus.mem_we       = r_mem_we;
   assign bus.mem_w        = r_mem_w;
   assign bus.mem_hw       = r_mem_hw;
   assign bus.mem_adr      = r_mem_adr;
   assign bus.mem_wdata    = r_mem_wdata;
   assign bus.read_valid   = r_read_valid;
   assign bus.read_data    = r_read_data;
   assign bus.write_finish = r_write_finish;
   assign bus.ext_done     = r_ext_done;
   assign bus.ext_rdata    = r_ext_rdata;
   assign bus.bus_err      = r_bus_err;
   assign bus.bus_err_adr  = r_bus_err_adr;
   assign bus.owner        = r_owner;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter; inputs change and outputs are
// sampled on the falling clock edge.
module tb_cpu_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   cpu_mem_arbiter_if bus();

   cpu_mem_arbiter #(.TMO_CYC(4), .TMO_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.i_read_req = 0; bus.i_read_w = 0; bus.i_read_hw = 0; bus.i_read_adr = '0;
      bus.d_read_req = 0; bus.d_read_w = 0; bus.d_read_hw = 0; bus.d_read_adr = '0;
      bus.d_write_req = 0; bus.d_write_w = 0; bus.d_write_hw = 0;
      bus.d_write_adr = '0; bus.d_write_data = '0;
      bus.ext_req = 0; bus.ext_we = 0; bus.ext_adr = '0; bus.ext_wdata = '0;
      bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.mem_wdone = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0h exp=0", bus.mem_req); end
      checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0h exp=0", bus.owner); end
      checks++; if ({bus.read_valid, bus.write_finish, bus.ext_done, bus.bus_err} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%0h exp=0", {bus.read_valid, bus.write_finish, bus.ext_done, bus.bus_err}); end
      checks++; if (bus.mem_adr !== 32'h0 || bus.read_data !== 32'h0 || bus.bus_err_adr !== 32'h0) begin failures++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0", bus.mem_adr, bus.read_data, bus.bus_err_adr); end
      rst = 1'b0;
      tick();
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%0h exp=0", bus.mem_req); end
   endtask

   task automatic test_ifetch();
      bus.i_read_req = 1; bus.i_read_w = 1; bus.i_read_adr = 32'h100;
      tick();
      checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL ifetch_mem_req got=%0h exp=1", bus.mem_req); end
      checks++; if (bus.mem_adr !== 32'h100 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL ifetch_cmd got=%0h/%0h exp=100/0", bus.mem_adr, bus.mem_we); end
      checks++; if (bus.owner !== 2'd1) begin failures++; $display("FAIL ifetch_owner got=%0h exp=1", bus.owner); end
      tick();
      checks++; if (bus.mem_req !== 1'b0 || bus.owner !== 2'd1) begin failures++; $display("FAIL ifetch_wait got=%0h/%0h exp=0/1", bus.mem_req, bus.owner); end
      tick();
      tick();
      // fourth WAIT cycle: response coincides with the timeout point
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h13;
      tick();
      bus.mem_rvalid = 0; bus.mem_rdata = 32'hFFFF_FFFF;
      checks++; if (bus.read_valid !== 1'b1 || bus.read_data !== 32'h13) begin failures++; $display("FAIL ifetch_done got=%0h/%0h exp=1/13", bus.read_valid, bus.read_data); end
      checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL ifetch_resp_beats_tmo got=%0h exp=0", bus.bus_err); end
      checks++; if (bus.owner !== 2'd1) begin failures++; $display("FAIL ifetch_owner_done got=%0h exp=1", bus.owner); end
      tick();
      checks++; if (bus.read_valid !== 1'b0 || bus.owner !== 2'd0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL ifetch_holdoff got=%0h/%0h/%0h exp=0/0/0", bus.read_valid, bus.owner, bus.mem_req); end
      checks++; if (bus.read_data !== 32'h13) begin failures++; $display("FAIL ifetch_data_hold got=%0h exp=13", bus.read_data); end
      bus.i_read_req = 0;
      tick();
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL ifetch_no_regrant got=%0h exp=0", bus.mem_req); end
   endtask

   task automatic test_priority();
      bus.d_read_req = 1; bus.d_read_w = 1; bus.d_read_hw = 1; bus.d_read_adr = 32'h400;
      bus.i_read_req = 1; bus.i_read_w = 1; bus.i_read_adr = 32'h100;
      tick();
      checks++; if (bus.mem_adr !== 32'h400 || bus.owner !== 2'd2) begin failures++; $display("FAIL prio_dread_first got=%0h/%0h exp=400/2", bus.mem_adr, bus.owner); end
      checks++; if (bus.mem_w !== 1'b1 || bus.mem_hw !== 1'b0) begin failures++; $display("FAIL prio_size_word got=%0h/%0h exp=1/0", bus.mem_w, bus.mem_hw); end
      bus.d_read_req = 0; bus.d_read_adr = 32'h999;
      bus.mem_rvalid = 1; bus.mem_rdata = 32'hAAAA;
      tick();
      bus.mem_rvalid = 0;
      checks++; if (bus.read_valid !== 1'b1 || bus.read_data !== 32'hAAAA) begin failures++; $display("FAIL prio_dread_done got=%0h/%0h exp=1/aaaa", bus.read_valid, bus.read_data); end
      checks++; if (bus.mem_adr !== 32'h400) begin failures++; $display("FAIL prio_latched_adr got=%0h exp=400", bus.mem_adr); end
      tick();
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_adr !== 32'h100 || bus.owner !== 2'd1) begin failures++; $display("FAIL prio_ifetch_next got=%0h/%0h/%0h exp=1/100/1", bus.mem_req, bus.mem_adr, bus.owner); end
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
      tick();
      bus.mem_rvalid = 0;
      checks++; if (bus.read_valid !== 1'b1 || bus.read_data !== 32'h55) begin failures++; $display("FAIL prio_ifetch_done got=%0h/%0h exp=1/55", bus.read_valid, bus.read_data); end
      bus.i_read_req = 0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_own [4];
      // last grant went to the CPU, so the EXT side wins the first tie
      exp_own[0] = 2'd3; exp_own[1] = 2'd1; exp_own[2] = 2'd3; exp_own[3] = 2'd1;
      bus.ext_req = 1; bus.ext_we = 0; bus.ext_adr = 32'h3000;
      bus.i_read_req = 1; bus.i_read_w = 1; bus.i_read_adr = 32'h100;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (bus.owner !== exp_own[k] || bus.mem_req !== 1'b1) begin failures++; $display("FAIL rr_grant%0d got=%0h/%0h exp=%0h/1", k, bus.owner, bus.mem_req, exp_own[k]); end
         bus.mem_rvalid = 1; bus.mem_rdata = 32'h70 + k;
         tick();
         bus.mem_rvalid = 0;
         checks++; if (bus.ext_done & bus.read_valid) begin failures++; $display("FAIL rr_both_done%0d got=1 exp=0", k); end
         if (exp_own[k] == 2'd3) begin
            checks++; if (bus.ext_done !== 1'b1 || bus.ext_rdata !== 32'h70 + k) begin failures++; $display("FAIL rr_ext_done%0d got=%0h/%0h exp=1/%0h", k, bus.ext_done, bus.ext_rdata, 32'h70 + k); end
         end else begin
            checks++; if (bus.read_valid !== 1'b1 || bus.read_data !== 32'h70 + k) begin failures++; $display("FAIL rr_cpu_done%0d got=%0h/%0h exp=1/%0h", k, bus.read_valid, bus.read_data, 32'h70 + k); end
         end
         tick();
      end
      bus.ext_req = 0; bus.i_read_req = 0;
      tick();
   endtask

   task automatic test_write();
      bus.d_write_req = 1; bus.d_write_w = 0; bus.d_write_hw = 1;
      bus.d_write_adr = 32'h2000; bus.d_write_data = 32'hCAFE_BABE;
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.owner !== 2'd2) begin failures++; $display("FAIL wr_cmd got=%0h/%0h/%0h exp=1/1/2", bus.mem_req, bus.mem_we, bus.owner); end
      checks++; if (bus.mem_hw !== 1'b1 || bus.mem_w !== 1'b0 || bus.mem_wdata !== 32'hCAFE_BABE || bus.mem_adr !== 32'h2000) begin failures++; $display("FAIL wr_fields got=%0h/%0h/%0h/%0h exp=1/0/cafebabe/2000", bus.mem_hw, bus.mem_w, bus.mem_wdata, bus.mem_adr); end
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h1;
      tick();
      checks++; if (bus.write_finish !== 1'b0 || bus.read_valid !== 1'b0) begin failures++; $display("FAIL wr_spurious_rvalid got=%0h/%0h exp=0/0", bus.write_finish, bus.read_valid); end
      bus.mem_rvalid = 0; bus.mem_wdone = 1;
      tick();
      bus.mem_wdone = 0;
      checks++; if (bus.write_finish !== 1'b1 || bus.read_valid !== 1'b0) begin failures++; $display("FAIL wr_finish got=%0h/%0h exp=1/0", bus.write_finish, bus.read_valid); end
      bus.d_write_req = 0;
      tick();
      checks++; if (bus.write_finish !== 1'b0 || bus.owner !== 2'd0) begin failures++; $display("FAIL wr_after got=%0h/%0h exp=0/0", bus.write_finish, bus.owner); end
   endtask

   task automatic test_timeout();
      bus.ext_req = 1; bus.ext_we = 0; bus.ext_adr = 32'hDEAD_0000;
      tick();
      checks++; if (bus.owner !== 2'd3 || bus.mem_w !== 1'b1 || bus.mem_hw !== 1'b0) begin failures++; $display("FAIL tmo_grant got=%0h/%0h/%0h exp=3/1/0", bus.owner, bus.mem_w, bus.mem_hw); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus.ext_done !== 1'b0 || bus.bus_err !== 1'b0) begin failures++; $display("FAIL tmo_early%0d got=%0h/%0h exp=0/0", k, bus.ext_done, bus.bus_err); end
      end
      tick();
      checks++; if (bus.ext_done !== 1'b1 || bus.ext_rdata !== 32'h0) begin failures++; $display("FAIL tmo_done got=%0h/%0h exp=1/0", bus.ext_done, bus.ext_rdata); end
      checks++; if (bus.bus_err !== 1'b1 || bus.bus_err_adr !== 32'hDEAD_0000) begin failures++; $display("FAIL tmo_err got=%0h/%0h exp=1/dead0000", bus.bus_err, bus.bus_err_adr); end
      bus.ext_req = 0;
      tick();
      checks++; if (bus.bus_err !== 1'b0 || bus.bus_err_adr !== 32'hDEAD_0000) begin failures++; $display("FAIL tmo_err_hold got=%0h/%0h exp=0/dead0000", bus.bus_err, bus.bus_err_adr); end
      bus.ext_req = 1; bus.ext_we = 1; bus.ext_adr = 32'h44; bus.ext_wdata = 32'h1234;
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1234) begin failures++; $display("FAIL tmo_next_cmd got=%0h/%0h/%0h exp=1/1/1234", bus.mem_req, bus.mem_we, bus.mem_wdata); end
      bus.mem_wdone = 1;
      tick();
      bus.mem_wdone = 0;
      checks++; if (bus.ext_done !== 1'b1 || bus.bus_err !== 1'b0) begin failures++; $display("FAIL tmo_next_done got=%0h/%0h exp=1/0", bus.ext_done, bus.bus_err); end
      bus.ext_req = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      bus.i_read_req = 1; bus.i_read_w = 1; bus.i_read_adr = 32'h500;
      tick();
      tick();
      checks++; if (bus.owner !== 2'd1) begin failures++; $display("FAIL rstmid_pre got=%0h exp=1", bus.owner); end
      rst = 1'b1;
      #1;
      checks++; if (bus.owner !== 2'd0 || bus.mem_adr !== 32'h0 || bus.read_data !== 32'h0 || bus.bus_err_adr !== 32'h0) begin failures++; $display("FAIL rstmid_outputs got=%0h/%0h/%0h/%0h exp=0", bus.owner, bus.mem_adr, bus.read_data, bus.bus_err_adr); end
      bus.i_read_req = 0;
      tick();
      rst = 1'b0;
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h99;
      tick();
      bus.mem_rvalid = 0;
      tick();
      checks++; if (bus.read_valid !== 1'b0 || bus.ext_done !== 1'b0 || bus.owner !== 2'd0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_late_resp got=%0h/%0h/%0h/%0h exp=0", bus.read_valid, bus.ext_done, bus.owner, bus.mem_req); end
      // after reset the CPU side wins a tie
      bus.i_read_req = 1; bus.ext_req = 1; bus.ext_we = 0; bus.ext_adr = 32'h3000;
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.owner !== 2'd1) begin failures++; $display("FAIL rstmid_rr_cpu got=%0h/%0h exp=1/1", bus.mem_req, bus.owner); end
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
      tick();
      bus.mem_rvalid = 0;
      bus.i_read_req = 0; bus.ext_req = 0;
      checks++; if (bus.read_valid !== 1'b1 || bus.read_data !== 32'h77) begin failures++; $display("FAIL rstmid_done got=%0h/%0h exp=1/77", bus.read_valid, bus.read_data); end
      tick();
   endtask

   initial begin
      test_reset();
      test_ifetch();
      test_priority();
      test_round_robin();
      test_write();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one memory port between the CPU's three access channels (instruction read, data read, data write) and one external master (DMA/loader).
- Sits between cpu_top's i_read_*/d_read_*/d_write_* ports and the memory controller.
- Returns the CPU's shared read_valid/read_data/write_finish and a separate external done/data path.
- Runs one transaction at a time, with a per-transaction timeout.

Parameters:
TMO_CYC, 255, cycles to wait for a memory response before forcing completion with error (1..2^TMO_W-1)
TMO_W, 8, timeout counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_read_req  in  1  CPU instruction read request (level)
i_read_w / i_read_hw  in  1/1  size: w=word, hw=halfword, both 0=byte
i_read_adr  in  32  instruction address
d_read_req  in  1  CPU data read request (level)
d_read_w / d_read_hw  in  1/1  size
d_read_adr  in  32  data read address
d_write_req  in  1  CPU data write request (level)
d_write_w / d_write_hw  in  1/1  size
d_write_adr  in  32  write address
d_write_data  in  32  write data
read_valid  out  1  CPU read complete, 1-cycle pulse
read_data  out  32  CPU read data, valid with read_valid
write_finish  out  1  CPU write complete, 1-cycle pulse
ext_req  in  1  external request (level)
ext_we  in  1  1=write, 0=read (always word)
ext_adr  in  32  external address
ext_wdata  in  32  external write data
ext_done  out  1  external complete, 1-cycle pulse
ext_rdata  out  32  external read data, valid with ext_done
mem_req  out  1  memory command strobe, 1-cycle pulse
mem_we  out  1  memory write
mem_w / mem_hw  out  1/1  memory size
mem_adr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rvalid  in  1  memory read data valid
mem_rdata  in  32  memory read data
mem_wdone  in  1  memory write done
bus_err  out  1  timeout pulse, coincident with the forced done
bus_err_adr  out  32  address of last timed-out transaction (held)
owner  out  2  0=idle,1=ifetch,2=cpu data,3=ext

Behaviour:
- Reset: all outputs 0; FSM=IDLE; rr flag=CPU-first; timeout counter=0. Async assertion mid-transaction aborts it; no done is issued.
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE with any request pending: grant, latch cmd/adr/size/wdata, assert mem_req for 1 cycle, go to WAIT.
- CPU channel priority: d_write > d_read > i_read.
- CPU vs EXT: round-robin. rr toggles to favour the other side after each granted transaction; a lone requester is always granted.
- mem_w/mem_hw = requester size bits. Both set = word. EXT forces mem_w=1, mem_hw=0.
- Latency: mem_req appears in the cycle after the request is seen in IDLE.
- WAIT, read grant: on mem_rvalid, register the response to the owner next cycle.
  - CPU: read_valid=1, read_data=mem_rdata.
  - EXT: ext_done=1, ext_rdata=mem_rdata.
- WAIT, write grant: on mem_wdone, write_finish=1 (CPU) or ext_done=1 (EXT).
- Response of the wrong type (mem_wdone during a read, or vice versa) is ignored.
- Done pulse goes out in the DONE state (one cycle), then the FSM returns to IDLE. Requester must drop req in the cycle after the done pulse; the DONE cycle is the hold-off, so a still-high req there is not re-granted.
- read_data/ext_rdata hold their value until the next read completes.
- Timeout: counter clears on grant and increments each WAIT cycle. When it reaches TMO_CYC with no response:
  - force a done to the owner; read data = 32'h0;
  - bus_err=1 for that cycle; bus_err_adr = latched address;
  - go to DONE.
- Response and timeout in the same cycle: the response wins, no bus_err.
- owner holds the grant value through WAIT and DONE; it is 0 in IDLE.
- Request inputs are ignored while in WAIT or DONE, and changes to them do not alter the latched command.

Test Plan:
- CPU i_read_req, adr=0x100, mem_rvalid 3 cycles after mem_req with 0x00000013 -> mem_req 1 cycle after req; read_valid 1 pulse, read_data=0x13; owner=1 during the transaction.
- d_read_req and i_read_req raised together -> d_read granted first (mem_adr=d_read_adr, owner=2); ifetch granted after DONE.
- CPU and EXT requesting continuously, responses immediate -> grants alternate CPU, EXT, CPU, EXT; ext_done and read_valid never in the same cycle.
- d_write_req adr=0x2000 data=0xCAFEBABE hw=1 -> mem_we=1, mem_hw=1, mem_wdata=0xCAFEBABE; a spurious mem_rvalid is ignored; write_finish pulses only after mem_wdone.
- TMO_CYC=4, ext read, no response -> after 4 WAIT cycles ext_done=1, ext_rdata=0, bus_err=1, bus_err_adr=ext_adr; next request is served normally.
- Assert rst during WAIT, then release -> all outputs 0 immediately; late mem_rvalid produces no done; FSM in IDLE.
